strobe_paced_tx: RTL
====================

STROBE_PACED_TX -- requirements
Module: strobe_paced_tx

Interface
REQ-001 Parameter DATA_W, default 8, width of the data word.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; power of two, 2..16.
REQ-003 Parameter PRIME_LVL, default 2, FIFO level needed before emission starts; 1..DEPTH.
REQ-004 iClk  input  1  clock; all state updates on the rising edge.
REQ-005 iRst  input  1  reset; asynchronous, active-low.
REQ-006 iEnable  input  1  one-cycle pacing strobe from the clock-enable generator.
REQ-007 iValid  input  1  upstream word valid.
REQ-008 iData  input  DATA_W  upstream word.
REQ-009 oReady  output  1  block can accept a word this cycle.
REQ-010 oValid  output  1  one-cycle pulse qualifying oData.
REQ-011 oData  output  DATA_W  emitted word; holds its last value when oValid is low.
REQ-012 oLevel  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 oUnderrun  output  1  one-cycle pulse: a strobe arrived in RUN with the FIFO empty.
REQ-014 oUnderrunCnt  output  8  underrun count (see Configuration).

Function
REQ-015 Push occurs when iValid && oReady; oReady = (level != DEPTH), combinational from registered level.
REQ-016 FSM states: PRIME, RUN. A strobe in PRIME never pops.
REQ-017 PRIME -> RUN when level >= PRIME_LVL at a clock edge; RUN is entered the cycle after that edge.
REQ-018 In RUN, a strobe with level > 0 pops the head; oData and oValid are registered, so oValid is high in the cycle after the strobe.
REQ-019 In RUN, a strobe with level == 0: no pop, oValid stays 0, oUnderrun pulses the next cycle, and the state returns to PRIME.
REQ-020 Push and pop in the same cycle: level is unchanged; there is no empty bypass, so a word pushed in cycle N can pop at the earliest on a strobe in cycle N+1.
REQ-021 When full, oReady = 0; an iValid held high is neither lost nor duplicated and is accepted once space frees.
REQ-022 Read and write pointers wrap modulo DEPTH; level is tracked in a separate counter, so it never aliases between full and empty.
REQ-023 iEnable high on consecutive cycles is legal; each strobe cycle is an independent pop request.
REQ-024 Words leave strictly in arrival order.

Reset
REQ-025 While iRst = 0: state = PRIME, pointers = 0, level = 0, oValid = 0, oData = 0, oUnderrun = 0, oUnderrunCnt = 0, oReady = 1.
REQ-026 Reset mid-stream discards all buffered words; no oValid pulse follows deassertion until the FIFO is re-primed.
REQ-027 Reset deassertion does not need to be synchronous with iClk.

Configuration
REQ-028 Macro STROBE_UNDERRUN_CNT_EN.
REQ-029 Macro defined: oUnderrunCnt increments on each oUnderrun pulse and saturates at 255.
REQ-030 Macro undefined: the counter is not built and oUnderrunCnt is tied to 0. All other behaviour is identical either way.

Structure
REQ-031 The shared package holds the FSM state enum (PRIME, RUN) and the default DATA_W, DEPTH and PRIME_LVL constants.
REQ-032 The storage is a sub-module, sync_fifo (push, pop, data, level, full, empty); strobe_paced_tx holds the FSM, output registers and underrun logic.

Verification
REQ-033 Priming: with default parameters, push 0x11 then 0x22, then strobe every 5 cycles -> no oValid before level reaches 2; then oData = 0x11 followed by oData = 0x22, each a 1-cycle oValid one cycle after its strobe.
REQ-034 Full: push 5 words with no strobes -> oReady = 0 after the 4th; the 5th word is held; after one RUN pop it is accepted and the output sequence is the 5 words in order.
REQ-035 Underrun: drain to empty in RUN, then strobe -> oUnderrun pulses once, state = PRIME, oUnderrunCnt = 1 (macro defined) or 0 (undefined).
REQ-036 Simultaneous: level = 1 in RUN, push 0x33 and strobe in the same cycle -> the old head is emitted and level stays 1.
REQ-037 Reset mid-stream: level = 3, assert iRst for 2 cycles -> all outputs at reset values; the next strobe after deassertion produces no oValid.
REQ-038 Saturation (macro defined): 300 forced underruns -> oUnderrunCnt = 255.

Source files
------------

// File: rtl/strobe_paced_tx_pkg.sv
// -----------------------------------------------------------------------------
// strobe_paced_tx_pkg
//   Shared definitions for the strobe-paced transmitter slice:
//     - default parameter values for DATA_W, DEPTH and PRIME_LVL
//     - FSM state encodings (legacy-compatible localparams) and the state enum
//     - a saturating 8-bit increment used by the optional underrun counter
//   Optional feature macro used by this slice: STROBE_UNDERRUN_CNT_EN.
// -----------------------------------------------------------------------------
package strobe_paced_tx_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_PRIME_LVL = 2;

  // Raw encodings kept for code that still compares against plain vectors.
  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  typedef enum logic [0:0] {
    PRIME = ST_PRIME,
    RUN   = ST_RUN
  } state_e;

  // Saturating increment: sticks at 255 instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/strobe_paced_tx_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO used as the word store of strobe_paced_tx.
//   Occupancy is kept in its own counter so full and empty never alias even
//   though both pointers wrap modulo DEPTH.
//
//   Ports
//     iClk     in   clock, rising edge
//     iRst     in   asynchronous active-low reset (pointers and level only)
//     push_i   in   write data_i (ignored when full)
//     pop_i    in   drop the head word (ignored when empty)
//     data_i   in   DATA_W write data
//     data_o   out  DATA_W head word (valid while not empty)
//     level_o  out  $clog2(DEPTH)+1 occupancy
//     full_o   out  level == DEPTH
//     empty_o  out  level == 0
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Storage is left unreset so it can map onto RAM primitives.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;

  logic push_ok;
  logic pop_ok;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i  && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leave the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Head word read directly; the consumer registers it on pop.
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/strobe_paced_tx.sv
// -----------------------------------------------------------------------------
// strobe_paced_tx
//   Buffers upstream words in a small FIFO and releases them one per pacing
//   strobe. Emission only starts once PRIME_LVL words are buffered; an empty
//   FIFO at a strobe in RUN is an underrun, which pulses oUnderrun and drops
//   back to PRIME so the buffer is refilled before emission resumes.
//
//   Parameters
//     DATA_W     word width
//     DEPTH      FIFO entries, power of two, 2..16
//     PRIME_LVL  occupancy required to leave PRIME, 1..DEPTH
//
//   Ports
//     iClk          in   clock, rising edge
//     iRst          in   asynchronous active-low reset
//     iEnable       in   one-cycle pacing strobe
//     iValid        in   upstream word valid
//     iData         in   upstream word
//     oReady        out  FIFO not full (from registered level)
//     oValid        out  one-cycle pulse qualifying oData
//     oData         out  emitted word, held between pulses
//     oLevel        out  FIFO occupancy
//     oUnderrun     out  one-cycle pulse after a strobe found the FIFO empty
//     oUnderrunCnt  out  saturating underrun count
//
//   Macro STROBE_UNDERRUN_CNT_EN builds the underrun counter; without it
//   oUnderrunCnt is constant zero and everything else behaves the same.
// -----------------------------------------------------------------------------
module strobe_paced_tx
  import strobe_paced_tx_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PRIME_LVL = DEF_PRIME_LVL
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iEnable,
  input  logic                       iValid,
  input  logic [DATA_W-1:0]          iData,
  output logic                       oReady,
  output logic                       oValid,
  output logic [DATA_W-1:0]          oData,
  output logic [$clog2(DEPTH):0]     oLevel,
  output logic                       oUnderrun,
  output logic [7:0]                 oUnderrunCnt
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] PRIME_THRESH = LVL_W'(PRIME_LVL);

  state_e state_q, state_d;

  logic              valid_q,    valid_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic              underrun_q, underrun_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full;
  logic              fifo_empty;

  logic              run_strobe;
  logic              underrun_evt;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .iClk    (iClk),
    .iRst    (iRst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (iData),
    .data_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A word offered while full stays on iValid until oReady returns.
  assign oReady    = !fifo_full;
  assign fifo_push = iValid && !fifo_full;

  // Strobes only matter in RUN; in PRIME they are simply ignored.
  assign run_strobe   = iEnable && (state_q == RUN);
  assign fifo_pop     = run_strobe && !fifo_empty;
  assign underrun_evt = run_strobe && fifo_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME: begin
        // Decided on the registered level, so RUN starts one cycle later.
        if (fifo_level >= PRIME_THRESH) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (underrun_evt) begin
          state_d = PRIME;
        end
      end
      default: state_d = PRIME;
    endcase
  end

  always_comb begin
    valid_d    = fifo_pop;
    data_d     = fifo_pop ? fifo_head : data_q;
    underrun_d = underrun_evt;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= PRIME;
      valid_q    <= 1'b0;
      data_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  assign oValid    = valid_q;
  assign oData     = data_q;
  assign oLevel    = fifo_level;
  assign oUnderrun = underrun_q;

`ifdef STROBE_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;

  // Counts on the same edge that raises oUnderrun, so the new value is
  // visible together with the pulse.
  always_comb begin
    ucnt_d = underrun_evt ? sat_inc8(ucnt_q) : ucnt_q;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign oUnderrunCnt = ucnt_q;
`else
  assign oUnderrunCnt = 8'd0;
`endif

endmodule
